// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester, apb_uart and their benches:
// FSM state encoding, UART register map and the timeout-counter width rule.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [2:0] {
    UART_CTRL   = 3'h0,
    UART_STATUS = 3'h1,
    UART_TX     = 3'h2,
    UART_RX     = 3'h3,
    UART_BAUD   = 3'h4
  } uart_reg_e;

  localparam logic [15:0] UART_BAUD_RESET = 16'd868;

  // A zero TIMEOUT still needs a one-bit counter so the port widths stay legal.
  function automatic int unsigned ctr_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command stream, response stream and APB bus of one requester, bundled
// with a requester-side (master) and environment-side (slave) view.
interface apb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_timeout,
    input  rsp_ready,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_timeout,
    output rsp_ready,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS-cycle counter; expired flags the last cycle allowed
// before the requester gives up on pready. TIMEOUT = 0 never expires.
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = ctr_width(TIMEOUT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge pclk) begin
    if (!presetn || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (count_reg == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one command in, one APB transfer out, one response back.
// Single outstanding transfer; all APB outputs come straight from registers.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic         pclk,
  input logic         presetn,
  apb_master_if.master bus
);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic              psel_reg;
  logic              penable_reg;
  logic              pwrite_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_timeout_reg;

  logic ctr_clear;
  logic ctr_enable;
  logic expired;

  assign ctr_clear  = (state_reg == ST_SETUP);
  assign ctr_enable = (state_reg == ST_ACCESS) && !bus.pready;

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (expired)
  );

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg       <= ST_IDLE;
      paddr_reg       <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            paddr_reg   <= bus.cmd_addr;
            pwrite_reg  <= bus.cmd_write;
            pwdata_reg  <= bus.cmd_wdata;
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
            state_reg   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready wins over an expiry landing on the same edge.
          if (bus.pready) begin
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_rdata_reg   <= pwrite_reg ? '0 : bus.prdata;
            rsp_timeout_reg <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= ST_RESP;
          end else if (expired) begin
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_timeout_reg <= 1'b1;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= ST_RESP;
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (state_reg == ST_IDLE);
  assign bus.paddr       = paddr_reg;
  assign bus.psel        = psel_reg;
  assign bus.penable     = penable_reg;
  assign bus.pwrite      = pwrite_reg;
  assign bus.pwdata      = pwdata_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;

endmodule
